// File: rtl/w5300_socket_reg_conf_pkg.sv
// W5300 socket register map, command/status codes and sequencer types
// shared by the socket configuration block and its SSR poller.
package w5300_socket_reg_conf_pkg;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;
  localparam logic [10:0] OP_IDLE = {RD, 10'h000};

  localparam logic [9:0] SN_MR    = 10'h000;
  localparam logic [9:0] SN_CR    = 10'h002;
  localparam logic [9:0] SN_IMR   = 10'h004;
  localparam logic [9:0] SN_SSR   = 10'h008;
  localparam logic [9:0] SN_PORTR = 10'h00a;

  localparam logic [15:0] CR_OPEN   = 16'h0001;
  localparam logic [15:0] CR_LISTEN = 16'h0002;

  localparam logic [7:0] SOCK_INIT   = 8'h13;
  localparam logic [7:0] SOCK_UDP    = 8'h22;
  localparam logic [7:0] SOCK_LISTEN = 8'h14;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_TCP = 2'd1,
    MODE_UDP = 2'd2
  } mode_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_WR_MR,
    S_WR_PORT,
    S_WR_IMR,
    S_WR_OPEN,
    S_WR_LISTEN,
    S_RD_SSR,
    S_CHECK,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_e;

  function automatic logic [9:0] sock_base(input logic [2:0] n);
    return 10'h200 + {1'b0, n, 6'b000000};
  endfunction

endpackage

// File: rtl/w5300_socket_reg_conf_if.sv
// Register-op bus between the configuration sequencers and the W5300 bus engine.
interface w5300_socket_reg_conf_if;
  logic [10:0] addr;
  logic [15:0] wr_data;
  logic        op_state;
  logic [15:0] rd_data;

  modport master (output addr, output wr_data, input op_state, input rd_data);
  modport slave  (input addr, input wr_data, output op_state, output rd_data);
endinterface

// File: rtl/w5300_ssr_poller.sv
// Sn_SSR poll engine: latches each status read and decides match, re-poll,
// re-open or timeout during the CHECK cycle.
module w5300_ssr_poller
  import w5300_socket_reg_conf_pkg::*;
#(
  parameter int POLL_MAX  = 64,
  parameter int RETRY_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  base,
  input  logic        clear,
  input  logic        latch,
  input  logic        check,
  input  logic [15:0] rd_data,
  input  logic [7:0]  expect_ssr,
  output logic [10:0] ssr_addr,
  output logic        match,
  output logic        poll_again,
  output logic        retry,
  output logic        timeout
);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_MAX - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);

  logic [7:0]    ssr;
  logic [PW-1:0] poll_cnt;
  logic [RW-1:0] retry_cnt;
  logic          hit;
  logic          polls_used;
  logic          unused_rd_hi;

  // only the low byte of Sn_SSR carries the socket status
  assign unused_rd_hi = ^rd_data[15:8];

  assign ssr_addr   = {RD, base + SN_SSR};
  assign hit        = (ssr == expect_ssr);
  assign polls_used = (poll_cnt >= POLL_LAST);
  assign match      = check && hit;
  assign poll_again = check && !hit && !polls_used;
  assign retry      = check && !hit && polls_used && (retry_cnt < RETRY_LAST);
  assign timeout    = check && !hit && polls_used && (retry_cnt >= RETRY_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssr       <= 8'h00;
      poll_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      if (latch) ssr <= rd_data[7:0];
      if (clear) begin
        poll_cnt  <= '0;
        retry_cnt <= '0;
      end else if (poll_again) begin
        poll_cnt <= poll_cnt + PW'(1);
      end else if (retry) begin
        poll_cnt  <= '0;
        retry_cnt <= retry_cnt + RW'(1);
      end
    end
  end

endmodule

// File: rtl/w5300_socket_reg_conf.sv
// Opens NUM_SOCKETS W5300 sockets in order after common setup (MR, PORT, IMR, OPEN, poll SSR).
// Defining W5300_SOCK_LISTEN_EN adds a LISTEN command and SOCK_LISTEN poll for TCP sockets.
module w5300_socket_reg_conf
  import w5300_socket_reg_conf_pkg::*;
#(
  parameter int          NUM_SOCKETS = 1,
  parameter int          POLL_MAX    = 64,
  parameter int          RETRY_MAX   = 2,
  parameter logic [15:0] IMR_VAL     = 16'h001f
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [2*NUM_SOCKETS-1:0]  sock_mode,
  input  logic [16*NUM_SOCKETS-1:0] sock_port,
  w5300_socket_reg_conf_if.master   bus,
  output logic                      done,
  output logic                      error,
  output logic [2:0]                err_sock
);
  localparam logic [2:0] LAST_IDX = 3'(NUM_SOCKETS - 1);

  state_e      state, state_nxt;
  logic [2:0]  idx;
  logic [1:0]  cur_mode;
  logic [15:0] cur_port;
  logic [9:0]  base;
  logic [7:0]  expect_ssr;
  logic        listen_phase;
  logic        listen_go;
  logic        poll_clear;
  logic [10:0] ssr_addr;
  logic        match, poll_again, retry, timeout;

  always_comb begin
    cur_mode = MODE_OFF;
    cur_port = 16'h0000;
    for (int i = 0; i < NUM_SOCKETS; i++) begin
      if (idx == 3'(i)) begin
        cur_mode = sock_mode[2*i +: 2];
        cur_port = sock_port[16*i +: 16];
      end
    end
  end

  assign base = sock_base(idx);

  always_comb begin
    if (listen_phase)                expect_ssr = SOCK_LISTEN;
    else if (cur_mode == MODE_TCP)   expect_ssr = SOCK_INIT;
    else                             expect_ssr = SOCK_UDP;
  end

`ifdef W5300_SOCK_LISTEN_EN
  assign listen_go = (cur_mode == MODE_TCP) && !listen_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         listen_phase <= 1'b0;
    else if (state == S_SEL)                         listen_phase <= 1'b0;
    else if (state == S_CHECK && match && listen_go) listen_phase <= 1'b1;
  end
`else
  assign listen_go    = 1'b0;
  assign listen_phase = 1'b0;
`endif

  // counters restart per socket and again when the LISTEN phase begins
  assign poll_clear = (state == S_SEL) || (state == S_CHECK && match && listen_go);

  w5300_ssr_poller #(
    .POLL_MAX  (POLL_MAX),
    .RETRY_MAX (RETRY_MAX)
  ) u_poller (
    .clk        (clk),
    .rst        (rst),
    .base       (base),
    .clear      (poll_clear),
    .latch      (state == S_RD_SSR && bus.op_state),
    .check      (state == S_CHECK),
    .rd_data    (bus.rd_data),
    .expect_ssr (expect_ssr),
    .ssr_addr   (ssr_addr),
    .match      (match),
    .poll_again (poll_again),
    .retry      (retry),
    .timeout    (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     idx <= 3'd0;
    else if (state == S_IDLE && enable)          idx <= 3'd0;
    else if (state == S_NEXT && idx != LAST_IDX) idx <= idx + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (enable) state_nxt = S_SEL;
      S_SEL:       state_nxt = (cur_mode == MODE_OFF) ? S_NEXT : S_WR_MR;
      S_WR_MR:     if (bus.op_state) state_nxt = S_WR_PORT;
      S_WR_PORT:   if (bus.op_state) state_nxt = S_WR_IMR;
      S_WR_IMR:    if (bus.op_state) state_nxt = S_WR_OPEN;
      S_WR_OPEN:   if (bus.op_state) state_nxt = S_RD_SSR;
      S_WR_LISTEN: if (bus.op_state) state_nxt = S_RD_SSR;
      S_RD_SSR:    if (bus.op_state) state_nxt = S_CHECK;
      S_CHECK: begin
        if (match)           state_nxt = listen_go ? S_WR_LISTEN : S_NEXT;
        else if (poll_again) state_nxt = S_RD_SSR;
        else if (retry)      state_nxt = listen_phase ? S_WR_LISTEN : S_WR_OPEN;
        else if (timeout)    state_nxt = S_ERROR;
      end
      S_NEXT:      state_nxt = (idx == LAST_IDX) ? S_DONE : S_SEL;
      S_DONE:      state_nxt = S_DONE;
      S_ERROR:     state_nxt = S_ERROR;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.addr    = OP_IDLE;
    bus.wr_data = 16'h0000;
    case (state)
      S_WR_MR: begin
        bus.addr    = {WR, base + SN_MR};
        bus.wr_data = {14'd0, cur_mode};
      end
      S_WR_PORT: begin
        bus.addr    = {WR, base + SN_PORTR};
        bus.wr_data = cur_port;
      end
      S_WR_IMR: begin
        bus.addr    = {WR, base + SN_IMR};
        bus.wr_data = IMR_VAL;
      end
      S_WR_OPEN: begin
        bus.addr    = {WR, base + SN_CR};
        bus.wr_data = CR_OPEN;
      end
      S_WR_LISTEN: begin
        bus.addr    = {WR, base + SN_CR};
        bus.wr_data = CR_LISTEN;
      end
      S_RD_SSR: bus.addr = ssr_addr;
      default: ;
    endcase
  end

  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign err_sock = error ? idx : 3'd0;

endmodule

// File: doc/w5300_socket_reg_conf.md
Name: w5300_socket_reg_conf

Overview:
- Sequencer that opens NUM_SOCKETS W5300 sockets after common-register setup has finished.
- Per socket it writes the mode, port and interrupt-mask registers, issues OPEN, and polls Sn_SSR until the socket reaches its expected status, with timeout and retry.
- It drives the same register-op bus as the common configuration block, ahead of the W5300 bus engine. The address is {rw, reg[9:0]}, and op_state pulses when the engine completes an op.
- Generalises the single-shot common sequence to N channels, adding read-back, polling and error reporting.

Parameters:
- NUM_SOCKETS, 1: number of sockets configured; legal range 1..8; sockets 0..NUM_SOCKETS-1 are handled in order.
- POLL_MAX, 64: maximum Sn_SSR reads per OPEN attempt before a timeout.
- RETRY_MAX, 2: number of re-OPEN attempts after a timeout before an error is flagged.
- IMR_VAL, 16'h001f: value written to each Sn_IMR.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  start; sampled in IDLE
- sock_mode  in  2*NUM_SOCKETS  per-socket protocol: 2'd1 TCP, 2'd2 UDP; 2'd0 means skip the socket
- sock_port  in  16*NUM_SOCKETS  per-socket source port
- op_state  in  1  one-cycle pulse: the current addr/wr_data op is complete; rd_data is valid in the same cycle
- rd_data  in  16  read result
- addr  out  11  bit 10 is 1 for write, 0 for read; bits 9:0 are the register address
- wr_data  out  16  write data
- done  out  1  high and held once all sockets are open
- error  out  1  high and held on a retry-exhausted failure
- err_sock  out  3  index of the failing socket

Behaviour:
- Reset is asynchronous, active-high. Reset values: state IDLE; addr 11'h000 (read of address 0, the idle op); wr_data 0; done 0; error 0; err_sock 0; all counters 0.
- Socket base address: 10'h200 + n*10'h40. Register offsets: MR +0x00, CR +0x02, IMR +0x04, SSR +0x08, PORTR +0x0A.
- State machine: IDLE -> SEL -> WR_MR -> WR_PORT -> WR_IMR -> WR_OPEN -> RD_SSR -> CHECK -> (NEXT | RD_SSR | WR_OPEN | ERROR) -> DONE.
- IDLE: on enable=1, go to SEL with socket index 0.
- SEL: if sock_mode[n]==0, go straight to NEXT (zero ops for that socket); otherwise go to WR_MR.
- Each WR_*/RD_* state drives addr/wr_data combinationally from the state and index. It advances only on the cycle op_state=1, so exactly one op completes per state. op_state seen in any other state is ignored.
- Write data:
  - WR_MR: {14'd0, mode}
  - WR_PORT: port
  - WR_IMR: IMR_VAL
  - WR_OPEN: 16'h0001
- RD_SSR: latch rd_data[7:0] when op_state=1, then go to CHECK next cycle.
- CHECK:
  - Status matches the expected value (0x13 for TCP, 0x22 for UDP): go to NEXT.
  - Otherwise, if poll count < POLL_MAX-1: increment poll count, go to RD_SSR.
  - Otherwise, if retry count < RETRY_MAX: clear poll count, increment retry count, go to WR_OPEN.
  - Otherwise: go to ERROR.
- Poll and retry counters clear on entering each socket.
- NEXT: if n==NUM_SOCKETS-1 go to DONE; otherwise increment n and go to SEL.
- DONE: done=1 and held, addr returns to the idle op. Only rst leaves DONE.
- ERROR: error=1, err_sock=n; both held until rst; addr idle.
- A successful single-poll socket takes exactly 5 ops: MR, PORT, IMR, OPEN, SSR.
- Counter widths: $clog2(POLL_MAX+1) and $clog2(RETRY_MAX+1); no wrap is possible.
- Reset mid-sequence aborts immediately. Any op in flight is abandoned; the bus engine must tolerate addr changing to the idle op.
- enable deasserting after start has no effect.

Optional Feature:
- Macro: W5300_SOCK_LISTEN_EN.
- When defined, after a TCP socket matches SOCK_INIT (0x13), the sequencer:
  - adds state WR_LISTEN (write CR = 16'h0002);
  - polls SSR for SOCK_LISTEN (0x14), using the same POLL_MAX/RETRY_MAX rules; a retry re-issues LISTEN.
- When undefined, TCP sockets finish at SOCK_INIT. UDP behaviour is identical either way.

Decomposition:
- Add to W5300 package:
  - socket offsets: Sn_MR, Sn_CR, Sn_IMR, Sn_SSR, Sn_PORTR
  - sock_base(n) function
  - command constants: CR_OPEN, CR_LISTEN
  - status constants: SOCK_INIT, SOCK_UDP, SOCK_LISTEN
  - mode enum: MODE_OFF, MODE_TCP, MODE_UDP
- Existing WR/RD constants are reused.
- One sub-module, w5300_ssr_poller: issues SSR reads, applies the compare, POLL_MAX and retry logic, and returns a match or timeout pulse.

Test Plan:
- NUM_SOCKETS=1, UDP on port 5000; model returns 0x22 on the first read -> ops in order: 0x600=0x0002, 0x60A=0x1388, 0x604=0x001f, 0x602=0x0001, then read 0x208; done=1 one cycle after CHECK.
- NUM_SOCKETS=3, modes {UDP, OFF, TCP} -> socket 1 issues zero ops; socket 2 writes 0x680=0x0001 and expects SSR 0x13; done after 10 ops.
- SSR returns 0x00 for 3 reads, then 0x13 -> exactly 4 SSR reads, no re-OPEN, done=1.
- POLL_MAX=4, RETRY_MAX=2, SSR stuck at 0x00 -> 3 OPEN writes, 12 SSR reads, then error=1, err_sock=0, done=0.
- rst asserted during WR_PORT of socket 1, then released and enable pulsed -> restarts at socket 0 MR; all outputs at reset values while rst is high.
- W5300_SOCK_LISTEN_EN defined, TCP socket -> after SSR reads 0x13, write CR=0x0002, poll SSR until 0x14, then done=1.
